// File: rtl/alu_selftest.sv
// BIST sequencer for the 16-bit ALU: LFSR vectors out, golden compare in, pass/fail counters.
// Latency: 2 + N*(2+SETTLE_CYC) cycles START-to-DONE (1 for N=0); START is ignored while BUSY_o is high.
module alu_selftest #(
  parameter int          SETTLE_CYC = 1,
  parameter logic [15:0] DEF_SEED   = 16'hACE1
) (
  input  logic        CLK_i,
  input  logic        RSTn_i,
  input  logic        START_i,
  input  logic [15:0] SEED_i,
  input  logic [15:0] NUM_VEC_i,
  output logic [15:0] ALU_A_o,
  output logic [15:0] ALU_B_o,
  output logic [3:0]  ALU_OP_o,
  output logic        ALU_CIN_o,
  input  logic [15:0] ALU_F_i,
  input  logic        ALU_COUT_i,
  output logic        BUSY_o,
  output logic        DONE_o,
  output logic [15:0] PASS_CNT_o,
  output logic [15:0] FAIL_CNT_o,
  output logic [15:0] FAIL_IDX_o,
  output logic [3:0]  FAIL_OP_o,
  output logic        FAIL_VLD_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRIVE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] seed_q, seed_d;
  logic [15:0] num_q, num_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] settle_q, settle_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        cin_q, cin_d;
  logic [15:0] pass_q, pass_d, fail_q, fail_d;
  logic [15:0] fidx_q, fidx_d;
  logic [3:0]  fop_q, fop_d;
  logic        fvld_q, fvld_d;

  logic [15:0] gold_f;
  logic        gold_c;
  logic [15:0] lfsr_a, lfsr_b;
  logic        match;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  assign lfsr_a = lfsr_step(lfsr_q);
  assign lfsr_b = lfsr_step(lfsr_a);

  // Golden model works from the registered vector, i.e. exactly what the ALU sees.
  always_comb begin
    gold_f = 16'd0;
    gold_c = 1'b0;
    case (op_q)
      4'h0: {gold_c, gold_f} = {1'b0, a_q} + {1'b0, b_q} + {16'd0, cin_q};
      4'h1: {gold_c, gold_f} = {1'b0, a_q} - {1'b0, b_q} - {16'd0, cin_q};
      4'h2: gold_f = {1'b0, a_q[15:1]};
      4'h3: gold_f = {a_q[14:0], 1'b0};
      4'h4: gold_f = {a_q[15], a_q[15:1]};
      4'h5: gold_f = {a_q[14:0], 1'b0};
      4'h6: gold_f = {a_q[0], a_q[15:1]};
      4'h7: gold_f = {a_q[14:0], a_q[15]};
      4'h8: gold_f = a_q;
      4'h9: gold_f = ~(a_q & b_q);
      4'hA: gold_f = ~(a_q | b_q);
      4'hB: gold_f = ~(a_q ^ b_q);
      4'hC: gold_f = ~a_q;
      4'hD: gold_f = a_q & b_q;
      4'hE: gold_f = a_q | b_q;
      default: gold_f = a_q ^ b_q;
    endcase
  end

  assign match = (ALU_F_i == gold_f) && (ALU_COUT_i == gold_c);

  always_comb begin
    state_d  = state_q;
    seed_d   = seed_q;
    num_d    = num_q;
    lfsr_d   = lfsr_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cin_d    = cin_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    fidx_d   = fidx_q;
    fop_d    = fop_q;
    fvld_d   = fvld_q;
    case (state_q)
      S_IDLE: begin
        if (START_i) begin
          seed_d  = SEED_i;
          num_d   = NUM_VEC_i;
          vec_d   = 16'd0;
          pass_d  = 16'd0;
          fail_d  = 16'd0;
          fidx_d  = 16'd0;
          fop_d   = 4'd0;
          fvld_d  = 1'b0;
          state_d = (NUM_VEC_i == 16'd0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        lfsr_d  = (seed_q == 16'd0) ? DEF_SEED : seed_q;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        a_d      = lfsr_a;
        b_d      = lfsr_b;
        cin_d    = lfsr_b[0];
        op_d     = vec_q[3:0];
        lfsr_d   = lfsr_b;
        settle_d = 16'd0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_CHECK;
        else settle_d = settle_q + 16'd1;
      end
      S_CHECK: begin
        if (match) begin
          pass_d = pass_q + 16'd1;
        end else begin
          fail_d = fail_q + 16'd1;
          if (!fvld_q) begin
            fidx_d = vec_q;
            fop_d  = op_q;
            fvld_d = 1'b1;
          end
        end
        vec_d   = vec_q + 16'd1;
        // 17-bit compare so N = 65535 cannot wrap the loop condition.
        state_d = (({1'b0, vec_q} + 17'd1) < {1'b0, num_q}) ? S_DRIVE : S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      state_q  <= S_IDLE;
      seed_q   <= 16'd0;
      num_q    <= 16'd0;
      lfsr_q   <= 16'd0;
      vec_q    <= 16'd0;
      settle_q <= 16'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      op_q     <= 4'd0;
      cin_q    <= 1'b0;
      pass_q   <= 16'd0;
      fail_q   <= 16'd0;
      fidx_q   <= 16'd0;
      fop_q    <= 4'd0;
      fvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      num_q    <= num_d;
      lfsr_q   <= lfsr_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cin_q    <= cin_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      fidx_q   <= fidx_d;
      fop_q    <= fop_d;
      fvld_q   <= fvld_d;
    end
  end

  assign ALU_A_o    = a_q;
  assign ALU_B_o    = b_q;
  assign ALU_OP_o   = op_q;
  assign ALU_CIN_o  = cin_q;
  assign BUSY_o     = (state_q != S_IDLE);
  assign DONE_o     = (state_q == S_FIN);
  assign PASS_CNT_o = pass_q;
  assign FAIL_CNT_o = fail_q;
  assign FAIL_IDX_o = fidx_q;
  assign FAIL_OP_o  = fop_q;
  assign FAIL_VLD_o = fvld_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: behavioural ALU (optionally faulty) on the port, vector stream and counts predicted independently.
module tb_alu_selftest;

  localparam int S = 1;

  logic        CLK_i = 1'b0;
  logic        RSTn_i;
  logic        START_i;
  logic [15:0] SEED_i, NUM_VEC_i;
  logic [15:0] ALU_A_o, ALU_B_o, ALU_F_i;
  logic [3:0]  ALU_OP_o;
  logic        ALU_CIN_o, ALU_COUT_i;
  logic        BUSY_o, DONE_o;
  logic [15:0] PASS_CNT_o, FAIL_CNT_o, FAIL_IDX_o;
  logic [3:0]  FAIL_OP_o;
  logic        FAIL_VLD_o;

  logic        fault_en, fault_kind;
  logic [3:0]  fault_op;

  int checks = 0;
  int errors = 0;

  alu_selftest #(.SETTLE_CYC(S), .DEF_SEED(16'hACE1)) dut (
    .CLK_i(CLK_i), .RSTn_i(RSTn_i), .START_i(START_i), .SEED_i(SEED_i), .NUM_VEC_i(NUM_VEC_i),
    .ALU_A_o(ALU_A_o), .ALU_B_o(ALU_B_o), .ALU_OP_o(ALU_OP_o), .ALU_CIN_o(ALU_CIN_o),
    .ALU_F_i(ALU_F_i), .ALU_COUT_i(ALU_COUT_i), .BUSY_o(BUSY_o), .DONE_o(DONE_o),
    .PASS_CNT_o(PASS_CNT_o), .FAIL_CNT_o(FAIL_CNT_o), .FAIL_IDX_o(FAIL_IDX_o),
    .FAIL_OP_o(FAIL_OP_o), .FAIL_VLD_o(FAIL_VLD_o)
  );

  always #5 CLK_i = ~CLK_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic: returns {carry, result}.
  function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
    int unsigned ua, ub, uc, sum;
    logic [15:0] f;
    logic        c;
    ua = a; ub = b; uc = cin;
    c = 1'b0;
    f = 16'd0;
    case (op)
      4'd0: begin sum = ua + ub + uc; f = 16'(sum); c = (sum > 32'hFFFF); end
      4'd1: begin f = 16'(ua - ub - uc); c = (ua < ub + uc); end
      4'd2: f = a >> 1;
      4'd3, 4'd5: f = a << 1;
      4'd4: f = 16'($signed(a) >>> 1);
      4'd6: f = (a >> 1) | (a << 15);
      4'd7: f = (a << 1) | (a >> 15);
      4'd8: f = a;
      4'd9: f = ~(a & b);
      4'd10: f = ~(a | b);
      4'd11: f = ~(a ^ b);
      4'd12: f = ~a;
      4'd13: f = a & b;
      4'd14: f = a | b;
      default: f = a ^ b;
    endcase
    return {c, f};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_comb begin
    {ALU_COUT_i, ALU_F_i} = alu_ref(ALU_OP_o, ALU_A_o, ALU_B_o, ALU_CIN_o);
    if (fault_en && ALU_OP_o == fault_op) begin
      if (fault_kind) ALU_COUT_i = ~ALU_COUT_i;
      else ALU_F_i = ~ALU_F_i;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_port"}, {ALU_A_o, ALU_B_o, ALU_OP_o, ALU_CIN_o, BUSY_o, DONE_o}, 64'd0);
    chk({tag, "_cnt"}, {PASS_CNT_o, FAIL_CNT_o, FAIL_IDX_o, FAIL_OP_o, FAIL_VLD_o}, 64'd0);
  endtask

  // One run; rst_at > 0 aborts it with an async reset in that cycle.
  task automatic run_test(input string tag, input logic [15:0] seed, input int n, input bit fen,
                          input logic [3:0] fop, input bit fkind, input bit restart_mid, input int rst_at);
    int d, done_c, done_n, busy_err, exp_fail, k;
    logic [15:0] s, ea, eb;
    d = (n == 0) ? 1 : 2 + n * (2 + S);
    exp_fail = 0;
    for (int i = 0; i < n; i++) if (fen && (i % 16) == fop) exp_fail++;
    s = (seed == 16'd0) ? 16'hACE1 : seed;
    done_c = -1; done_n = 0; busy_err = 0;
    fault_en = fen; fault_op = fop; fault_kind = fkind;
    @(negedge CLK_i);
    START_i = 1'b1; SEED_i = seed; NUM_VEC_i = 16'(n);
    for (int c = 1; c <= d + 3; c++) begin
      @(negedge CLK_i);
      SEED_i = 16'h1234;
      if (rst_at > 0 && c == rst_at) begin
        chk({tag, "_pre_rst_pass"}, PASS_CNT_o, 64'd5);
        #2 RSTn_i = 1'b0;
        #1 check_all_zero({tag, "_rst"});
        START_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge CLK_i);
          if (DONE_o || BUSY_o) done_n++;
        end
        chk({tag, "_rst_nodone"}, done_n, 64'd0);
        RSTn_i = 1'b1;
        return;
      end
      if (BUSY_o !== (c <= d)) busy_err++;
      if (DONE_o) begin
        if (done_c < 0) done_c = c;
        done_n++;
      end
      if (n > 0 && c >= 3 && c < 3 + n * (2 + S) && ((c - 3) % (2 + S)) == 0) begin
        k = (c - 3) / (2 + S);
        s = lfsr_next(s); ea = s;
        s = lfsr_next(s); eb = s;
        chk({tag, "_vec"}, {ALU_A_o, ALU_B_o, ALU_OP_o, ALU_CIN_o}, {ea, eb, 4'(k), eb[0]});
      end
      if (c == d) chk({tag, "_cnt_at_done"}, {PASS_CNT_o, FAIL_CNT_o}, {16'(n - exp_fail), 16'(exp_fail)});
      // Extra STARTs mid-run and coincident with DONE must both be ignored.
      START_i = (restart_mid && c == 4) || (c == d);
      if (restart_mid && c == 4) NUM_VEC_i = 16'd20;
    end
    START_i = 1'b0;
    chk({tag, "_done_cyc"}, done_c, d);
    chk({tag, "_done_n"}, done_n, 64'd1);
    chk({tag, "_busy"}, busy_err, 64'd0);
    chk({tag, "_pass"}, PASS_CNT_o, 16'(n - exp_fail));
    chk({tag, "_fail"}, FAIL_CNT_o, 16'(exp_fail));
    chk({tag, "_fvld"}, FAIL_VLD_o, exp_fail > 0);
    if (exp_fail > 0) chk({tag, "_fidx_op"}, {FAIL_IDX_o, FAIL_OP_o}, {16'(fop), fop});
  endtask

  initial begin
    RSTn_i = 1'b0; START_i = 1'b0; SEED_i = 16'd0; NUM_VEC_i = 16'd0;
    fault_en = 1'b0; fault_op = 4'd0; fault_kind = 1'b0;
    repeat (2) @(negedge CLK_i);
    check_all_zero("reset");
    RSTn_i = 1'b1;

    chk("spot_add", alu_ref(4'd0, 16'hFFFF, 16'hFFFF, 1'b0), {1'b1, 16'hFFFE});
    chk("spot_sub", alu_ref(4'd1, 16'h0000, 16'hFFFF, 1'b1), {1'b1, 16'h0000});
    chk("spot_rl", alu_ref(4'd7, 16'hF000, 16'h0000, 1'b0), {1'b0, 16'hE001});
    chk("spot_ars", alu_ref(4'd4, 16'hFFFA, 16'h0000, 1'b0), {1'b0, 16'hFFFD});

    run_test("good16", 16'hACE1, 16, 1'b0, 4'd0, 1'b0, 1'b0, 0);
    run_test("xor_bad", 16'hACE1, 32, 1'b1, 4'hF, 1'b0, 1'b0, 0);
    run_test("n0", 16'h5555, 0, 1'b0, 4'd0, 1'b0, 1'b0, 0);
    run_test("restart", 16'h0BAD, 8, 1'b0, 4'd0, 1'b0, 1'b1, 0);
    run_test("abort", 16'hACE1, 40, 1'b0, 4'd0, 1'b0, 1'b0, 3 + 5 * (2 + S));
    run_test("after_rst", 16'hACE1, 16, 1'b1, 4'd1, 1'b1, 1'b0, 0);
    run_test("seed0", 16'h0000, 16, 1'b0, 4'd0, 1'b0, 1'b0, 0);

    for (int r = 0; r < 10; r++) begin
      run_test("rand", 16'($urandom), int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
